// File: rtl/mnet_pkg.sv
// Shared types and helpers for the requantization path.
// Holds default widths, the group config bundle and saturation.
package mnet_pkg;

  localparam int ACC_W   = 48;
  localparam int DATA_W  = 16;
  localparam int SHIFT_W = 6;

  typedef struct packed {
    logic signed [ACC_W-1:0]  bias;
    logic        [SHIFT_W-1:0] shift;
    logic                      relu6;
    logic signed [DATA_W-1:0] six;
  } rq_cfg_t;

  function automatic logic signed [DATA_W-1:0] sat_data(
    input logic signed [ACC_W:0] v
  );
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    hi = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = ~hi;
    if (v > hi)
      return hi[DATA_W-1:0];
    else if (v < lo)
      return lo[DATA_W-1:0];
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a write into a full FIFO is accepted
// only when a read happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Head is forced to zero when empty so reset shows a clean bus.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_rd)
        rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)
        count <= count + (AW+1)'(1);
      else if (do_rd && !do_wr)
        count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/psum_requant.sv
// Accumulates partial sums per pixel, adds bias, rounds,
// clamps and saturates, then queues results for the consumer.
module psum_requant #(
  parameter int ACC_W      = mnet_pkg::ACC_W,
  parameter int DATA_W     = mnet_pkg::DATA_W,
  parameter int CNT_W      = 12,
  parameter int SHIFT_W    = mnet_pkg::SHIFT_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     psum_valid,
  input  logic signed [ACC_W-1:0]  psum_in,
  input  logic        [CNT_W-1:0]  cfg_k,
  input  logic signed [ACC_W-1:0]  cfg_bias,
  input  logic        [SHIFT_W-1:0] cfg_shift,
  input  logic                     cfg_relu6,
  input  logic signed [DATA_W-1:0] cfg_six,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     err_overflow
);
  import mnet_pkg::*;

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [SHIFT_W-1:0] SH_MAX = SHIFT_W'(ACC_W-1);

  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        k_l;
  logic [CNT_W-1:0]        k_now;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_base;
  logic                    last;
  logic                    a_vld;
  rq_cfg_t                 g_cfg;
  rq_cfg_t                 cfg_now;

  logic [SHIFT_W-1:0]      sh;
  logic signed [ACC_W:0]   acc_x;
  logic signed [ACC_W:0]   rnd_sum;
  logic signed [ACC_W:0]   y_next;
  logic                    b_vld;
  logic signed [ACC_W:0]   y_b;
  logic                    b_relu6;
  logic signed [DATA_W-1:0] b_six;

  logic signed [ACC_W:0]   six_x;
  logic signed [ACC_W:0]   y_c;
  logic [DATA_W-1:0]       wr_data;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic                    wr_ok;
  logic [FAW:0]            fifo_count_unused;

  // Config is taken from the ports only on a group's first psum.
  always_comb begin
    cfg_now = g_cfg;
    k_now   = k_l;
    if (cnt == '0) begin
      cfg_now.bias  = cfg_bias;
      cfg_now.shift = (cfg_shift > SH_MAX) ? SH_MAX : cfg_shift;
      cfg_now.relu6 = cfg_relu6;
      cfg_now.six   = cfg_six;
      k_now = (cfg_k == '0) ? CNT_W'(1) : cfg_k;
    end
  end

  assign acc_base = (cnt == '0) ? cfg_now.bias : acc;
  assign last     = (cnt == k_now - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      k_l   <= '0;
      acc   <= '0;
      a_vld <= 1'b0;
      g_cfg <= '0;
    end else begin
      a_vld <= 1'b0;
      if (psum_valid) begin
        acc   <= acc_base + psum_in;
        g_cfg <= cfg_now;
        k_l   <= k_now;
        if (last) begin
          cnt   <= '0;
          a_vld <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // One extra bit keeps the round-half-up add from overflowing.
  assign sh      = g_cfg.shift;
  assign acc_x   = {acc[ACC_W-1], acc};
  assign rnd_sum = acc_x + ((ACC_W+1)'(1) << (sh - SHIFT_W'(1)));
  assign y_next  = (sh == '0) ? acc_x : (rnd_sum >>> sh);

  always_ff @(posedge clk) begin
    if (rst) begin
      b_vld   <= 1'b0;
      y_b     <= '0;
      b_relu6 <= 1'b0;
      b_six   <= '0;
    end else begin
      b_vld <= a_vld;
      if (a_vld) begin
        y_b     <= y_next;
        b_relu6 <= g_cfg.relu6;
        b_six   <= g_cfg.six;
      end
    end
  end

  assign six_x = {{(ACC_W+1-DATA_W){b_six[DATA_W-1]}}, b_six};

  always_comb begin
    y_c = y_b;
    if (b_relu6) begin
      if (y_c < 0)
        y_c = '0;
      if (y_c > six_x)
        y_c = six_x;
    end
  end

  assign wr_data = sat_data(y_c);
  assign pop     = out_valid && out_ready;
  assign wr_ok   = !full || pop;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (b_vld),
    .wr_data (wr_data),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count_unused)
  );

  assign out_valid = !empty;
  assign busy      = (cnt != '0) || a_vld || b_vld;

  always_ff @(posedge clk) begin
    if (rst)
      err_overflow <= 1'b0;
    else if (b_vld && !wr_ok)
      err_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_psum_requant.sv
// Directed and randomized checks of psum_requant against
// an arithmetic reference model.
module tb_psum_requant;

  logic               clk = 1'b0;
  logic               rst;
  logic               psum_valid;
  logic signed [47:0] psum_in;
  logic [11:0]        cfg_k;
  logic signed [47:0] cfg_bias;
  logic [5:0]         cfg_shift;
  logic               cfg_relu6;
  logic signed [15:0] cfg_six;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_ready;
  logic               busy;
  logic               err_overflow;

  int     vectors = 0;
  int     miscompares = 0;
  longint expq[$];
  bit     mon = 1'b0;

  psum_requant dut (
    .clk          (clk),
    .rst          (rst),
    .psum_valid   (psum_valid),
    .psum_in      (psum_in),
    .cfg_k        (cfg_k),
    .cfg_bias     (cfg_bias),
    .cfg_shift    (cfg_shift),
    .cfg_relu6    (cfg_relu6),
    .cfg_six      (cfg_six),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .busy         (busy),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  function automatic longint wrap48(input longint x);
    return (x <<< 16) >>> 16;
  endfunction

  function automatic longint ref_out(
    input longint acc, input int sh,
    input bit relu, input longint six
  );
    longint y;
    int s;
    s = (sh > 47) ? 47 : sh;
    if (s == 0)
      y = acc;
    else
      y = (acc + (longint'(1) <<< (s - 1))) >>> s;
    if (relu) begin
      if (y < 0) y = 0;
      if (y > six) y = six;
    end
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  function automatic longint rnd_wide();
    longint r;
    r = {$urandom(), $urandom()};
    return r >>> $urandom_range(16, 62);
  endfunction

  task automatic chk(
    input string tag,
    input logic signed [63:0] obs,
    input logic signed [63:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input longint p);
    @(negedge clk);
    if (mon && out_valid && out_ready) begin
      if (expq.size() == 0)
        chk("rand_unexpected_pop", out_valid, 0);
      else
        chk("rand_out", out_data, expq.pop_front());
    end
    psum_valid = v;
    psum_in    = p[47:0];
  endtask

  task automatic set_cfg(
    input int k, input longint bias, input int sh,
    input bit relu, input int six
  );
    cfg_k     = 12'(k);
    cfg_bias  = bias[47:0];
    cfg_shift = 6'(sh);
    cfg_relu6 = relu;
    cfg_six   = 16'(six);
  endtask

  task automatic pop_check(input string tag, input longint exp);
    int n;
    step(1'b0, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk({tag, "_timeout"}, out_valid, 1);
    end else begin
      chk(tag, out_data, exp);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    psum_valid = 1'b0;
    out_ready  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    longint p;
    longint macc;
    longint msix;
    int     mcnt;
    int     mk;
    int     msh;
    bit     mrl;
    bit     v;

    rst        = 1'b1;
    psum_valid = 1'b0;
    psum_in    = '0;
    out_ready  = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_overflow, 0);
    rst = 1'b0;

    // basic group and latency
    set_cfg(3, 10, 2, 0, 0);
    step(1'b1, 100);
    step(1'b1, 200);
    step(1'b1, -50);
    step(1'b0, 0);
    chk("lat_busy", busy, 1);
    chk("lat_t1", out_valid, 0);
    step(1'b0, 0);
    chk("lat_t2", out_valid, 0);
    step(1'b0, 0);
    chk("lat_t3", out_valid, 1);
    chk("basic_data", out_data, 65);
    pop_check("basic_pop", 65);
    step(1'b0, 0);
    chk("basic_empty", out_valid, 0);
    chk("basic_idle", busy, 0);

    // relu6 and negative rounding
    set_cfg(1, 0, 2, 1, 96);
    step(1'b1, 2000);
    step(1'b1, -400);
    pop_check("relu_hi", 96);
    pop_check("relu_lo", 0);
    set_cfg(1, 0, 1, 0, 96);
    step(1'b1, -5);
    pop_check("neg_round", -2);

    // saturation
    set_cfg(1, 0, 0, 0, 0);
    step(1'b1, longint'(1) <<< 20);
    step(1'b1, -(longint'(1) <<< 20));
    step(1'b1, 1234);
    pop_check("sat_pos", 32767);
    pop_check("sat_neg", -32768);
    pop_check("sat_pass", 1234);

    // overflow under backpressure
    set_cfg(1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      step(1'b1, i);
    repeat (4) step(1'b0, 0);
    chk("ovf_err", err_overflow, 1);
    for (int i = 1; i <= 4; i++)
      pop_check("ovf_pop", i);
    step(1'b0, 0);
    chk("ovf_drained", out_valid, 0);
    chk("ovf_sticky", err_overflow, 1);

    // simultaneous pop and write at full
    do_reset();
    chk("rst_clears_err", err_overflow, 0);
    set_cfg(1, 0, 0, 0, 0);
    for (int i = 11; i <= 14; i++)
      step(1'b1, i);
    repeat (4) step(1'b0, 0);
    chk("full_head", out_data, 11);
    step(1'b1, 15);
    step(1'b0, 0);
    step(1'b0, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("full_no_drop", err_overflow, 0);
    for (int i = 12; i <= 15; i++)
      pop_check("full_pop", i);
    step(1'b0, 0);
    chk("full_drained", out_valid, 0);

    // reset in the middle of a group
    set_cfg(3, 0, 0, 0, 0);
    step(1'b1, 7);
    step(1'b1, 7);
    do_reset();
    chk("rst_mid_busy", busy, 0);
    set_cfg(2, 3, 0, 0, 0);
    step(1'b1, 4);
    step(1'b1, 5);
    pop_check("rst_mid", 12);

    // config change inside a group is ignored
    set_cfg(2, 0, 1, 0, 0);
    step(1'b1, 10);
    step(1'b1, 11);
    cfg_shift = 6'd3;
    pop_check("cfg_mid", 11);

    // randomized stream, config randomized every cycle
    mon       = 1'b1;
    out_ready = 1'b1;
    mcnt      = 0;
    macc      = 0;
    mk        = 1;
    msh       = 0;
    mrl       = 1'b0;
    msix      = 0;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (i >= 580 && mcnt != 0) v = 1'b1;
      if (i >= 580 && mcnt == 0) v = 1'b0;
      p = rnd_wide();
      step(v, p);
      set_cfg($urandom_range(0, 4), rnd_wide(),
              $urandom_range(0, 63), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) == 0 ?
                $urandom_range(0, 40000) : $urandom_range(0, 200));
      if (v) begin
        if (mcnt == 0) begin
          mk   = (cfg_k == 0) ? 1 : int'(cfg_k);
          msh  = int'(cfg_shift);
          mrl  = cfg_relu6;
          msix = longint'(cfg_six);
          macc = longint'(cfg_bias);
        end
        macc = wrap48(macc + p);
        mcnt++;
        if (mcnt == mk) begin
          expq.push_back(ref_out(macc, msh, mrl, msix));
          mcnt = 0;
        end
      end
    end
    repeat (8) step(1'b0, 0);
    chk("rand_drain", expq.size(), 0);
    chk("rand_no_ovf", err_overflow, 0);
    chk("rand_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
